// File: rtl/sideband_pkg.sv
// Shared types for the sideband frame reader: descriptor layout, reader FSM states
// and a saturating increment for the error counter.
package sideband_pkg;

    localparam int SB_LEN_W = 12;

    typedef struct packed {
        logic                drop;
        logic [2:0]          port;
        logic [3:0]          rsvd;
        logic [SB_LEN_W-1:0] len;
    } sb_desc_t;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        FETCH  = 2'd1,
        STREAM = 2'd2,
        DRAIN  = 2'd3
    } rd_state_t;

    function automatic logic [7:0] sat_inc8(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

endpackage

// File: rtl/sideband_skid2.sv
// Two-entry valid/ready skid buffer; the head entry drives the output and holds
// until accepted, so the egress side sees stable data under backpressure.
module sideband_skid2 #(
    parameter int W = 10
) (
    input  logic         clk_i,
    input  logic         reset_i,
    input  logic         in_valid_i,
    input  logic [W-1:0] in_data_i,
    input  logic         out_ready_i,
    output logic         out_valid_o,
    output logic [W-1:0] out_data_o,
    output logic [1:0]   count_o
);

    logic [W-1:0] ent0_q;
    logic [W-1:0] ent1_q;
    logic [1:0]   count_q;
    logic         pop_s;

    assign pop_s       = out_ready_i && (count_q != 2'd0);
    assign out_valid_o = (count_q != 2'd0);
    assign out_data_o  = ent0_q;
    assign count_o     = count_q;

    // Entry storage and occupancy; a push into a full buffer is ignored (upstream gates it).
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            ent0_q  <= '0;
            ent1_q  <= '0;
            count_q <= 2'd0;
        end else begin
            case ({in_valid_i, pop_s})
                2'b10: begin
                    if (count_q == 2'd0) begin
                        ent0_q  <= in_data_i;
                        count_q <= 2'd1;
                    end else if (count_q == 2'd1) begin
                        ent1_q  <= in_data_i;
                        count_q <= 2'd2;
                    end
                end
                2'b01: begin
                    ent0_q  <= ent1_q;
                    count_q <= count_q - 2'd1;
                end
                2'b11: begin
                    if (count_q == 2'd1) begin
                        ent0_q <= in_data_i;
                    end else begin
                        ent0_q <= ent1_q;
                        ent1_q <= in_data_i;
                    end
                end
                default: begin
                    count_q <= count_q;
                end
            endcase
        end
    end

endmodule

// File: rtl/sideband_frame_reader.sv
// Pops one sideband descriptor per frame, then streams (or silently drains) that
// many beats from the frame FIFO into a 2-entry skid buffer feeding egress.
module sideband_frame_reader
    import sideband_pkg::*;
#(
    parameter int W_DATA = 8,
    parameter int W_DESC = 20,
    parameter int W_CNT  = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [W_DESC-1:0] sb_rdata,
    input  logic              sb_empty,
    output logic              sb_ren,
    input  logic [W_DATA-1:0] fr_rdata,
    input  logic              fr_empty,
    output logic              fr_ren,
    output logic [W_DATA-1:0] out_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              out_sop,
    output logic              out_eop,
    output logic [2:0]        out_port,
    output logic              busy,
    output logic [W_CNT-1:0]  frames_sent,
    output logic [W_CNT-1:0]  frames_dropped,
    output logic [7:0]        desc_errors
);

    rd_state_t           state_q;
    logic [SB_LEN_W-1:0] rem_q;
    logic [2:0]          port_q;
    logic                sop_pend_q;
    logic                inflight_q;
    logic                infl_sop_q;
    logic                infl_eop_q;
    logic [W_CNT-1:0]    sent_q;
    logic [W_CNT-1:0]    dropped_q;
    logic [7:0]          err_q;

    sb_desc_t            desc_s;
    logic                rsvd_unused_s;
    logic [1:0]          skid_cnt_s;
    logic                skid_push_s;
    logic                skid_pop_s;
    logic                room_s;
    logic [W_DATA+1:0]   skid_out_s;

    assign desc_s        = sb_desc_t'(sb_rdata);
    assign rsvd_unused_s = ^desc_s.rsvd;

    // Only beats read while streaming enter the skid; drained beats are discarded.
    assign skid_push_s = inflight_q && (state_q == STREAM);
    assign skid_pop_s  = out_valid && out_ready;
    // Occupancy after this cycle's accept plus the read still in flight must leave a free slot.
    assign room_s = (({1'b0, skid_cnt_s} + {2'b00, inflight_q}) - {2'b00, skid_pop_s}) < 3'd2;

    // FIFO pop requests, evaluated against this cycle's empty flags.
    always_comb begin
        sb_ren = 1'b0;
        fr_ren = 1'b0;
        if (reset) begin
            sb_ren = 1'b0;
            fr_ren = 1'b0;
        end else begin
            case (state_q)
                IDLE:    sb_ren = !sb_empty;
                STREAM:  fr_ren = !fr_empty && (rem_q != 12'd0) && room_s;
                DRAIN:   fr_ren = !fr_empty && (rem_q != 12'd0);
                default: begin
                    sb_ren = 1'b0;
                    fr_ren = 1'b0;
                end
            endcase
        end
    end

    sideband_skid2 #(
        .W (W_DATA + 2)
    ) u_skid (
        .clk_i       (clk),
        .reset_i     (reset),
        .in_valid_i  (skid_push_s),
        .in_data_i   ({fr_rdata, infl_sop_q, infl_eop_q}),
        .out_ready_i (out_ready),
        .out_valid_o (out_valid),
        .out_data_o  (skid_out_s),
        .count_o     (skid_cnt_s)
    );

    assign out_data       = skid_out_s[W_DATA+1:2];
    assign out_sop        = skid_out_s[1];
    assign out_eop        = skid_out_s[0];
    assign out_port       = port_q;
    assign busy           = (state_q != IDLE);
    assign frames_sent    = sent_q;
    assign frames_dropped = dropped_q;
    assign desc_errors    = err_q;

    // Reader FSM, beat accounting, in-flight tagging and statistics.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= IDLE;
            rem_q      <= 12'd0;
            port_q     <= 3'd0;
            sop_pend_q <= 1'b0;
            inflight_q <= 1'b0;
            infl_sop_q <= 1'b0;
            infl_eop_q <= 1'b0;
            sent_q     <= '0;
            dropped_q  <= '0;
            err_q      <= 8'd0;
        end else begin
            inflight_q <= fr_ren;
            infl_sop_q <= fr_ren && sop_pend_q;
            infl_eop_q <= fr_ren && (rem_q == 12'd1);
            if (fr_ren) begin
                rem_q      <= rem_q - 12'd1;
                sop_pend_q <= 1'b0;
            end
            case (state_q)
                IDLE: begin
                    if (sb_ren) begin
                        state_q <= FETCH;
                    end
                end
                FETCH: begin
                    if (desc_s.len == 12'd0) begin
                        err_q   <= sat_inc8(err_q);
                        state_q <= IDLE;
                    end else begin
                        port_q     <= desc_s.port;
                        rem_q      <= desc_s.len;
                        sop_pend_q <= 1'b1;
                        state_q    <= desc_s.drop ? DRAIN : STREAM;
                    end
                end
                STREAM: begin
                    if (skid_pop_s && out_eop) begin
                        sent_q  <= sent_q + {{(W_CNT-1){1'b0}}, 1'b1};
                        state_q <= IDLE;
                    end
                end
                DRAIN: begin
                    if ((rem_q == 12'd0) && !inflight_q) begin
                        dropped_q <= dropped_q + {{(W_CNT-1){1'b0}}, 1'b1};
                        state_q   <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_sideband_frame_reader.sv
// Bench acting as owner of both FIFOs; a descriptor-level model predicts egress beats and counters.
module tb_sideband_frame_reader;

    logic        clk = 1'b0;
    logic        reset;
    logic [19:0] sb_rdata;
    logic        sb_empty;
    logic        sb_ren;
    logic [7:0]  fr_rdata;
    logic        fr_empty;
    logic        fr_ren;
    logic [7:0]  out_data;
    logic        out_valid;
    logic        out_ready;
    logic        out_sop;
    logic        out_eop;
    logic [2:0]  out_port;
    logic        busy;
    logic [15:0] frames_sent;
    logic [15:0] frames_dropped;
    logic [7:0]  desc_errors;

    sideband_frame_reader #(.W_DATA(8), .W_DESC(20), .W_CNT(16)) dut (
        .clk            (clk),
        .reset          (reset),
        .sb_rdata       (sb_rdata),
        .sb_empty       (sb_empty),
        .sb_ren         (sb_ren),
        .fr_rdata       (fr_rdata),
        .fr_empty       (fr_empty),
        .fr_ren         (fr_ren),
        .out_data       (out_data),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .out_sop        (out_sop),
        .out_eop        (out_eop),
        .out_port       (out_port),
        .busy           (busy),
        .frames_sent    (frames_sent),
        .frames_dropped (frames_dropped),
        .desc_errors    (desc_errors)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    logic [19:0] sb_q[$];
    logic [8:0]  fr_q[$];
    logic [12:0] exp_q[$];

    int sent_m, drop_m, err_m;
    int stream_reads, accepted, max_out;
    int viol_empty, viol_both, viol_hold;
    int ready_mode, stall_cnt, rand_stall_pct, cyc, first_acc, last_acc;
    bit stall_arm, stall, prev_v, prev_r;
    logic [12:0] prev_beat, got_beat;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic add_frame(input bit drop, input logic [2:0] port, input int len, input logic [7:0] base);
        logic [11:0] l;
        logic [7:0]  d;
        l = len[11:0];
        sb_q.push_back({drop, port, 4'($urandom), l});
        if (len == 0) begin
            err_m = (err_m < 255) ? err_m + 1 : 255;
        end else begin
            for (int i = 0; i < len; i++) begin
                d = base + 8'(i);
                fr_q.push_back({drop, d});
                if (!drop) exp_q.push_back({d, (i == 0), (i == len - 1), port});
            end
            if (drop) drop_m++;
            else sent_m++;
        end
    endtask

    task automatic tick();
        bit sbr, frr;
        logic [8:0] e;
        @(negedge clk);
        cyc++;
        case (ready_mode)
            0:       out_ready = 1'b1;
            1:       out_ready = (cyc % 3 == 0);
            default: out_ready = ($urandom_range(0, 9) < 7);
        endcase
        if (stall_arm && fr_q.size() == 3) begin
            stall_cnt = 10;
            stall_arm = 1'b0;
        end
        stall = 1'b0;
        if (stall_cnt > 0) begin
            stall = 1'b1;
            stall_cnt--;
        end else if (rand_stall_pct > 0 && $urandom_range(0, 99) < rand_stall_pct) begin
            stall = 1'b1;
        end
        fr_empty = (fr_q.size() == 0) || stall;
        sb_empty = (sb_q.size() == 0);
        #1;
        if (fr_ren && fr_empty) viol_empty++;
        if (sb_ren && fr_ren) viol_both++;
        got_beat = {out_data, out_sop, out_eop, out_port};
        if (prev_v && !prev_r && (!out_valid || got_beat != prev_beat)) viol_hold++;
        if (stream_reads - accepted > max_out) max_out = stream_reads - accepted;
        if (out_valid && out_ready) begin
            if (exp_q.size() == 0) check_val("unexpected_beat", 32'(exp_q.size()), 32'd1);
            else check_val("beat", 32'(got_beat), 32'(exp_q.pop_front()));
            accepted++;
            if (first_acc < 0) first_acc = cyc;
            last_acc = cyc;
        end
        prev_v = out_valid;
        prev_r = out_ready;
        prev_beat = got_beat;
        sbr = sb_ren;
        frr = fr_ren;
        @(posedge clk);
        #1;
        if (sbr && sb_q.size() > 0) sb_rdata = sb_q.pop_front();
        if (frr && fr_q.size() > 0) begin
            e = fr_q.pop_front();
            fr_rdata = e[7:0];
            if (!e[8]) stream_reads++;
        end
    endtask

    task automatic run_until_idle(input int budget, input string tag);
        int n;
        n = 0;
        do begin
            tick();
            n++;
        end while (n < budget && !(exp_q.size() == 0 && sb_q.size() == 0 && fr_q.size() == 0 && !busy));
        check_val({tag, "_done"}, 32'(n < budget), 32'd1);
    endtask

    task automatic check_counters(input string tag);
        check_val({tag, "_sent"}, 32'(frames_sent), 32'(sent_m[15:0]));
        check_val({tag, "_dropped"}, 32'(frames_dropped), 32'(drop_m[15:0]));
        check_val({tag, "_errs"}, 32'(desc_errors), 32'(err_m[7:0]));
    endtask

    initial begin
        int n;
        reset = 1'b1; out_ready = 1'b0; sb_empty = 1'b1; fr_empty = 1'b1;
        sb_rdata = 20'd0; fr_rdata = 8'd0;
        sent_m = 0; drop_m = 0; err_m = 0;
        stream_reads = 0; accepted = 0; max_out = 0;
        viol_empty = 0; viol_both = 0; viol_hold = 0;
        ready_mode = 0; stall_cnt = 0; rand_stall_pct = 0; cyc = 0;
        first_acc = -1; last_acc = -1;
        stall_arm = 1'b0; stall = 1'b0; prev_v = 1'b0; prev_r = 1'b0; prev_beat = 13'd0;

        repeat (2) @(negedge clk);
        #1;
        check_val("rst_outs", 32'({sb_ren, fr_ren, out_valid, out_sop, out_eop, out_port, busy}), 32'd0);
        check_counters("rst");
        @(negedge clk);
        reset = 1'b0;

        // Basic frame, egress always ready
        add_frame(1'b0, 3'd3, 4, 8'hA1);
        run_until_idle(60, "t1");
        check_val("t1_gapless", 32'(last_acc - first_acc), 32'd3);
        check_counters("t1");

        // Same frame under 1,0,0 backpressure
        ready_mode = 1;
        add_frame(1'b0, 3'd3, 4, 8'hA1);
        run_until_idle(80, "t2");
        check_counters("t2");

        // Dropped frame followed by a delivered one
        ready_mode = 0;
        add_frame(1'b1, 3'd5, 3, 8'h30);
        add_frame(1'b0, 3'd1, 2, 8'h40);
        run_until_idle(80, "t3");
        check_counters("t3");

        // Zero-length descriptor then a single-beat frame
        add_frame(1'b0, 3'd2, 0, 8'h00);
        add_frame(1'b0, 3'd6, 1, 8'h55);
        run_until_idle(60, "t4");
        check_counters("t4");

        // Frame FIFO runs dry mid-frame for 10 cycles
        stall_arm = 1'b1;
        add_frame(1'b0, 3'd4, 5, 8'h60);
        run_until_idle(100, "t5");
        check_counters("t5");

        // Randomised traffic
        ready_mode = 2;
        rand_stall_pct = 20;
        for (int f = 0; f < 40; f++) begin
            add_frame($urandom_range(0, 3) == 0, 3'($urandom), $urandom_range(0, 9), 8'($urandom));
        end
        run_until_idle(4000, "rand");
        check_counters("rand");

        // desc_errors saturation
        ready_mode = 0;
        rand_stall_pct = 0;
        for (int k = 0; k < 260; k++) add_frame(1'b0, 3'd0, 0, 8'h00);
        run_until_idle(2000, "sat");
        check_counters("sat");
        check_val("err_saturated", 32'(desc_errors), 32'd255);

        // Reset while streaming
        add_frame(1'b0, 3'd7, 8, 8'h80);
        n = 0;
        do begin
            tick();
            n++;
        end while (!out_valid && n < 40);
        check_val("t6_streaming", 32'(out_valid), 32'd1);
        @(negedge clk);
        reset = 1'b1;
        #1;
        check_val("rst_mid_outs", 32'({sb_ren, fr_ren, out_valid, out_sop, out_eop, out_port, busy}), 32'd0);
        check_val("rst_mid_cnts", 32'({frames_sent, frames_dropped}), 32'd0);
        check_val("rst_mid_errs", 32'(desc_errors), 32'd0);
        sb_q.delete(); fr_q.delete(); exp_q.delete();
        sent_m = 0; drop_m = 0; err_m = 0;
        stream_reads = 0; accepted = 0; prev_v = 1'b0;
        sb_empty = 1'b1; fr_empty = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        add_frame(1'b0, 3'd2, 2, 8'hC0);
        run_until_idle(60, "t6");
        check_counters("t6");

        check_val("no_ren_when_empty", 32'(viol_empty), 32'd0);
        check_val("no_dual_ren", 32'(viol_both), 32'd0);
        check_val("hold_under_backpressure", 32'(viol_hold), 32'd0);
        check_val("max_outstanding_le2", 32'(max_out <= 2), 32'd1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
